// File: rtl/game_tick_gen_if.sv
// game_tick_gen_if: control inputs and strobe/status outputs of the game timebase.
interface game_tick_gen_if;
  logic       start;
  logic       pause;
  logic       stop;
  logic [1:0] speed;
  logic       tick;
  logic       half_tick;
  logic       blink;
  logic       running;
  logic [1:0] state;
  modport master (output start, pause, stop, speed, input tick, half_tick, blink, running, state);
  modport slave  (input start, pause, stop, speed, output tick, half_tick, blink, running, state);
endinterface

// File: rtl/game_tick_gen.sv
// game_tick_gen: programmable timebase emitting tick/half_tick strobes with run/pause/stop control.
module game_tick_gen #(
  parameter int DIV_BASE = 50000000,
  parameter int CNT_W    = 26
) (
  input logic           clk,
  input logic           resetN,
  game_tick_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  localparam logic [CNT_W-1:0] BASE = CNT_W'(DIV_BASE);
  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n, period, period_n;
  logic tick, tick_n, half, half_n, blink, blink_n, running;
  logic wrap, mid;
  assign wrap = cnt == period - CNT_W'(1);
  assign mid  = cnt == (period >> 1) - CNT_W'(1);
  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    period_n = period;
    tick_n   = 1'b0;
    half_n   = 1'b0;
    blink_n  = blink;
    if (bus.stop) begin
      st_n    = IDLE;
      cnt_n   = '0;
      blink_n = 1'b0;
    end else if (st == IDLE) begin
      if (bus.start) begin
        st_n     = RUN;
        cnt_n    = '0;
        period_n = BASE >> bus.speed;
      end
    end else if (st == PAUSE) begin
      st_n = (bus.start || bus.pause) ? RUN : PAUSE;
    end else begin
      // speed is only resampled at the period wrap, so a mid-period change waits a period
      cnt_n    = wrap ? '0 : cnt + CNT_W'(1);
      period_n = wrap ? BASE >> bus.speed : period;
      tick_n   = wrap;
      half_n   = wrap || mid;
      blink_n  = blink ^ (wrap || mid);
      st_n     = bus.pause ? PAUSE : RUN;
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st      <= IDLE;
      cnt     <= '0;
      period  <= BASE;
      tick    <= 1'b0;
      half    <= 1'b0;
      blink   <= 1'b0;
      running <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      period  <= period_n;
      tick    <= tick_n;
      half    <= half_n;
      blink   <= blink_n;
      running <= st_n == RUN;
    end
  end
  assign bus.tick      = tick;
  assign bus.half_tick = half;
  assign bus.blink     = blink;
  assign bus.running   = running;
  assign bus.state     = st;
endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: per-edge vector table plus hand sequences for async reset and restart latency.
module tb_game_tick_gen;
  localparam logic [1:0] SI = 2'b00, SR = 2'b01, SP = 2'b10;
  typedef struct {
    logic       start;
    logic       pause;
    logic       stop;
    logic [1:0] speed;
    logic [5:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int checks = 0;
  int fails = 0;
  vec_t tv[$];
  game_tick_gen_if bus();
  game_tick_gen #(.DIV_BASE(16), .CNT_W(5)) dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;
  wire [5:0] outs = {bus.tick, bus.half_tick, bus.blink, bus.running, bus.state};
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  task automatic ev(input logic s, input logic p, input logic t, input logic [1:0] sp,
                    input logic tk, input logic hf, input logic bl, input logic [1:0] stt);
    vec_t v;
    v.start = s;
    v.pause = p;
    v.stop  = t;
    v.speed = sp;
    v.exp   = {tk, hf, bl, stt == SR, stt};
    tv.push_back(v);
  endtask
  task automatic q(input int n, input logic [1:0] sp, input logic bl, input logic [1:0] stt);
    repeat (n) ev(1'b0, 1'b0, 1'b0, sp, 1'b0, 1'b0, bl, stt);
  endtask
  initial begin
    int n;
    // speed 0: ticks at 16/32/48, half ticks every 8 edges, blink alternating
    ev(1, 0, 0, 0, 0, 0, 0, SR);
    q(7, 0, 0, SR); ev(0, 0, 0, 0, 0, 1, 1, SR);
    q(7, 0, 1, SR); ev(0, 0, 0, 0, 1, 1, 0, SR);
    q(7, 0, 0, SR); ev(0, 0, 0, 0, 0, 1, 1, SR);
    q(7, 0, 1, SR); ev(0, 0, 0, 0, 1, 1, 0, SR);
    q(7, 0, 0, SR); ev(0, 0, 0, 0, 0, 1, 1, SR);
    q(7, 0, 1, SR); ev(0, 0, 0, 0, 1, 1, 0, SR);
    // speed -> 2 at cnt=5: current period keeps 16, then period 4
    q(5, 0, 0, SR); q(2, 2, 0, SR); ev(0, 0, 0, 2, 0, 1, 1, SR);
    q(7, 2, 1, SR); ev(0, 0, 0, 2, 1, 1, 0, SR);
    q(1, 2, 0, SR); ev(0, 0, 0, 2, 0, 1, 1, SR);
    q(1, 2, 1, SR); ev(0, 0, 0, 2, 1, 1, 0, SR);
    q(1, 2, 0, SR); ev(0, 0, 0, 2, 0, 1, 1, SR);
    q(1, 2, 1, SR); ev(0, 0, 0, 2, 1, 1, 0, SR);
    ev(0, 0, 1, 2, 0, 0, 0, SI);
    // pause holding cnt=6 for 20 cycles, resume: tick after 10 edges
    ev(1, 0, 0, 0, 0, 0, 0, SR);
    q(5, 0, 0, SR); ev(0, 1, 0, 0, 0, 0, 0, SP);
    q(20, 0, 0, SP); ev(1, 0, 0, 0, 0, 0, 0, SR);
    q(1, 0, 0, SR); ev(0, 0, 0, 0, 0, 1, 1, SR);
    q(7, 0, 1, SR); ev(0, 0, 0, 0, 1, 1, 0, SR);
    // stop on the wrap edge suppresses the tick, restart gives a full period
    q(7, 0, 0, SR); ev(0, 0, 0, 0, 0, 1, 1, SR);
    q(7, 0, 1, SR); ev(0, 0, 1, 0, 0, 0, 0, SI);
    ev(1, 0, 0, 0, 0, 0, 0, SR);
    q(7, 0, 0, SR); ev(0, 0, 0, 0, 0, 1, 1, SR);
    q(7, 0, 1, SR); ev(0, 0, 0, 0, 1, 1, 0, SR);
    // priority and ignored inputs
    ev(0, 1, 1, 0, 0, 0, 0, SI);
    ev(1, 0, 1, 0, 0, 0, 0, SI);
    ev(0, 1, 0, 0, 0, 0, 0, SI);
    q(2, 0, 0, SI);
    // start ignored in RUN, pause on the wrap edge still ticks
    ev(1, 0, 0, 0, 0, 0, 0, SR);
    ev(1, 0, 0, 0, 0, 0, 0, SR);
    q(6, 0, 0, SR); ev(0, 0, 0, 0, 0, 1, 1, SR);
    q(7, 0, 1, SR); ev(0, 1, 0, 0, 1, 1, 0, SP);
    q(3, 0, 0, SP); ev(0, 1, 0, 0, 0, 0, 0, SR);
    q(7, 0, 0, SR); ev(0, 0, 0, 0, 0, 1, 1, SR);
    ev(0, 0, 1, 0, 0, 0, 0, SI);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    bus.speed = 2'd0;
    #12;
    check("reset_outputs", 32'(outs), 32'h0);
    resetN = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      bus.start = tv[i].start;
      bus.pause = tv[i].pause;
      bus.stop  = tv[i].stop;
      bus.speed = tv[i].speed;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), 32'(outs), 32'(tv[i].exp));
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    // asynchronous reset at cnt=9, observed before any further edge
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset_state", 32'(outs), 32'h0D);
    #2 resetN = 1'b0;
    #1 check("async_reset", 32'(outs), 32'h0);
    #2 resetN = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.tick && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_tick_after_reset", 32'(n), 32'd16);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
